// File: rtl/dma_burst_engine_if.sv
// DMA read/write channel bundle between the burst engine (master)
// and the DMA block (slave).
interface dma_burst_engine_if #(
    parameter int ADDR_WIDTH = 64,
    parameter int DATA_WIDTH = 512,
    parameter int SIZE_WIDTH = 16
);
    logic [ADDR_WIDTH-1:0] dma_rd_addr;
    logic [SIZE_WIDTH-1:0] dma_rd_size;
    logic                  dma_rd_go;
    logic                  dma_rd_en;
    logic [DATA_WIDTH-1:0] dma_rd_data;
    logic                  dma_empty;
    logic                  dma_rd_done;
    logic [ADDR_WIDTH-1:0] dma_wr_addr;
    logic [SIZE_WIDTH-1:0] dma_wr_size;
    logic                  dma_wr_go;
    logic                  dma_wr_en;
    logic [DATA_WIDTH-1:0] dma_wr_data;
    logic                  dma_full;
    logic                  dma_wr_done;

    modport master (
        output dma_rd_addr,
        output dma_rd_size,
        output dma_rd_go,
        output dma_rd_en,
        input  dma_rd_data,
        input  dma_empty,
        input  dma_rd_done,
        output dma_wr_addr,
        output dma_wr_size,
        output dma_wr_go,
        output dma_wr_en,
        output dma_wr_data,
        input  dma_full,
        input  dma_wr_done
    );

    modport slave (
        input  dma_rd_addr,
        input  dma_rd_size,
        input  dma_rd_go,
        input  dma_rd_en,
        output dma_rd_data,
        output dma_empty,
        output dma_rd_done,
        input  dma_wr_addr,
        input  dma_wr_size,
        input  dma_wr_go,
        input  dma_wr_en,
        input  dma_wr_data,
        output dma_full,
        output dma_wr_done
    );
endinterface

// File: rtl/dma_burst_engine.sv
// Moves SIZE lines from the DMA read channel (or a fill pattern) to the
// DMA write channel through a line FIFO. DMA_BURST_PERF_EN adds cycle_count.
module dma_burst_engine #(
    parameter int ADDR_WIDTH = 64,
    parameter int DATA_WIDTH = 512,
    parameter int SIZE_WIDTH = 16,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  go,
    input  logic                  mode,
    input  logic [ADDR_WIDTH-1:0] rd_base,
    input  logic [ADDR_WIDTH-1:0] wr_base,
    input  logic [SIZE_WIDTH-1:0] size,
    input  logic [DATA_WIDTH-1:0] pattern,
    output logic                  busy,
    output logic                  done,
`ifdef DMA_BURST_PERF_EN
    output logic [31:0]           cycle_count,
`endif
    dma_burst_engine_if.master    dma
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_XFER,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t                state;
    logic                  go_q;
    logic                  busy_q;
    logic                  done_q;
    logic                  rd_go_q;
    logic                  wr_go_q;
    logic                  mode_q;
    logic [ADDR_WIDTH-1:0] rd_addr_q;
    logic [ADDR_WIDTH-1:0] wr_addr_q;
    logic [SIZE_WIDTH-1:0] size_q;
    logic [SIZE_WIDTH-1:0] rd_cnt;
    logic [SIZE_WIDTH-1:0] wr_cnt;
    logic [DATA_WIDTH-1:0] pattern_q;
    logic                  rd_seen;
    logic                  wr_seen;

    logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
    logic [PW-1:0]         wptr;
    logic [PW-1:0]         rptr;
    logic [CW-1:0]         count;

    logic                  go_edge;
    logic                  accept;
    logic                  in_xfer;
    logic                  has_space;
    logic                  push;
    logic                  pop;
    logic                  drain_ok;
    logic [DATA_WIDTH-1:0] push_data;

    assign go_edge   = go & ~go_q;
    assign accept    = go_edge &&
                       (state == S_IDLE || state == S_DONE);
    assign in_xfer   = (state == S_XFER);
    assign has_space = count < CW'(FIFO_DEPTH);

    assign push = in_xfer && has_space &&
                  (rd_cnt < size_q) &&
                  (mode_q || !dma.dma_empty);
    assign pop  = in_xfer && (count != '0) &&
                  !dma.dma_full;

    // Fill lines are numbered by the push index
    assign push_data = mode_q ?
                       pattern_q + DATA_WIDTH'(rd_cnt) :
                       dma.dma_rd_data;

    // Done pulses may arrive before DRAIN, so they are also remembered
    assign drain_ok = (wr_seen || dma.dma_wr_done) &&
                      (mode_q || rd_seen || dma.dma_rd_done);

    assign busy            = busy_q;
    assign done            = done_q;
    assign dma.dma_rd_addr = rd_addr_q;
    assign dma.dma_rd_size = size_q;
    assign dma.dma_rd_go   = rd_go_q;
    assign dma.dma_rd_en   = push && !mode_q;
    assign dma.dma_wr_addr = wr_addr_q;
    assign dma.dma_wr_size = size_q;
    assign dma.dma_wr_go   = wr_go_q;
    assign dma.dma_wr_en   = pop;
    assign dma.dma_wr_data = mem[rptr];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= S_IDLE;
            go_q      <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            rd_go_q   <= 1'b0;
            wr_go_q   <= 1'b0;
            mode_q    <= 1'b0;
            rd_addr_q <= '0;
            wr_addr_q <= '0;
            size_q    <= '0;
            pattern_q <= '0;
            rd_cnt    <= '0;
            wr_cnt    <= '0;
            rd_seen   <= 1'b0;
            wr_seen   <= 1'b0;
        end else begin
            go_q    <= go;
            rd_go_q <= 1'b0;
            wr_go_q <= 1'b0;
            if (busy_q) begin
                rd_seen <= rd_seen | dma.dma_rd_done;
                wr_seen <= wr_seen | dma.dma_wr_done;
            end
            if (push) begin
                rd_cnt <= rd_cnt + SIZE_WIDTH'(1);
            end
            if (pop) begin
                wr_cnt <= wr_cnt + SIZE_WIDTH'(1);
            end
            unique case (state)
                S_IDLE, S_DONE: begin
                    if (accept) begin
                        state     <= S_START;
                        busy_q    <= 1'b1;
                        done_q    <= 1'b0;
                        mode_q    <= mode;
                        rd_addr_q <= rd_base;
                        wr_addr_q <= wr_base;
                        size_q    <= size;
                        pattern_q <= pattern;
                        rd_cnt    <= '0;
                        wr_cnt    <= '0;
                        rd_seen   <= 1'b0;
                        wr_seen   <= 1'b0;
                        wr_go_q   <= (size != '0);
                        rd_go_q   <= (size != '0) && !mode;
                    end
                end
                S_START: begin
                    if (size_q == '0) begin
                        state  <= S_DONE;
                        busy_q <= 1'b0;
                        done_q <= 1'b1;
                    end else begin
                        state <= S_XFER;
                    end
                end
                S_XFER: begin
                    if (wr_cnt == size_q) begin
                        state <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    if (drain_ok) begin
                        state  <= S_DONE;
                        busy_q <= 1'b0;
                        done_q <= 1'b1;
                    end
                end
                default: begin
                    state  <= S_IDLE;
                    busy_q <= 1'b0;
                    done_q <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (accept) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (push) begin
                mem[wptr] <= push_data;
                wptr      <= wptr + PW'(1);
            end
            if (pop) begin
                rptr <= rptr + PW'(1);
            end
            count <= count + CW'(push) - CW'(pop);
        end
    end

`ifdef DMA_BURST_PERF_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cycle_count <= '0;
        end else if (accept) begin
            cycle_count <= '0;
        end else if (busy_q && cycle_count != '1) begin
            cycle_count <= cycle_count + 32'(1);
        end
    end
`endif

endmodule

// File: tb/tb_dma_burst_engine.sv
// Randomized bench for dma_burst_engine: a DMA channel emulation plus a
// transfer-level reference model checked every cycle, with directed cases.
`timescale 1ns/1ps
module tb_dma_burst_engine;
    localparam int AW = 64;
    localparam int DW = 512;
    localparam int SW = 16;
    localparam int FD = 8;

    typedef enum int {M_IDLE, M_START, M_XFER, M_DRAIN, M_DONE} ph_t;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          go = 1'b0;
    logic          mode = 1'b0;
    logic [AW-1:0] rd_base = '0;
    logic [AW-1:0] wr_base = '0;
    logic [SW-1:0] size = '0;
    logic [DW-1:0] pattern = '0;
    logic          busy;
    logic          done;
`ifdef DMA_BURST_PERF_EN
    logic [31:0]   cycle_count;
    logic [31:0]   m_cyc = '0;
`endif

    dma_burst_engine_if #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .SIZE_WIDTH(SW)
    ) dif ();

    dma_burst_engine #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW),
        .SIZE_WIDTH(SW), .FIFO_DEPTH(FD)
    ) dut (
        .clk(clk),
        .rst(rst),
        .go(go),
        .mode(mode),
        .rd_base(rd_base),
        .wr_base(wr_base),
        .size(size),
        .pattern(pattern),
        .busy(busy),
        .done(done),
`ifdef DMA_BURST_PERF_EN
        .cycle_count(cycle_count),
`endif
        .dma(dif)
    );

    always #5 clk = ~clk;

    int errs = 0;
    int checks = 0;

    // Reference model state
    ph_t           ph = M_IDLE;
    logic          go_prev = 1'b0;
    logic          m_mode = 1'b0;
    logic [AW-1:0] m_rd = '0;
    logic [AW-1:0] m_wr = '0;
    logic [SW-1:0] m_size = '0;
    int            pushes = 0;
    int            pops = 0;
    bit            rd_seen = 0;
    bit            wr_seen = 0;
    int            post_rd = -1;
    int            post_wr = -1;
    int            rd_dly = 0;
    int            wr_dly = 0;
    logic [DW-1:0] src_q[$];
    logic [DW-1:0] exp_q[$];
    logic [DW-1:0] src_log[$];
    logic [DW-1:0] wlog[$];

    // Observed pulse counts
    int   n_rd_en = 0;
    int   n_wr_en = 0;
    int   n_rd_go = 0;
    int   n_wr_go = 0;
    int   n_done_rise = 0;
    logic done_prev = 1'b0;

    int empty_pct = 0;
    int full_pct = 0;
    bit force_full = 0;

    int b_rd, b_wr, b_rg, b_wg, b_dn, b_wl;

    task automatic check(input string nm,
                         input logic [DW-1:0] act,
                         input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    function automatic logic [DW-1:0] rnd_line();
        logic [DW-1:0] v;
        for (int k = 0; k < DW / 32; k++) v[k*32 +: 32] = $urandom;
        return v;
    endfunction

    task automatic mreset();
        ph = M_IDLE;
        go_prev = 1'b0;
        m_mode = 1'b0;
        m_rd = '0;
        m_wr = '0;
        m_size = '0;
        pushes = 0;
        pops = 0;
        rd_seen = 0;
        wr_seen = 0;
        post_rd = -1;
        post_wr = -1;
        src_q.delete();
        exp_q.delete();
`ifdef DMA_BURST_PERF_EN
        m_cyc = '0;
`endif
    endtask

    task automatic maccept();
        logic [DW-1:0] v;
        m_mode = mode;
        m_rd = rd_base;
        m_wr = wr_base;
        m_size = size;
        pushes = 0;
        pops = 0;
        rd_seen = 0;
        wr_seen = 0;
        post_rd = -1;
        post_wr = -1;
        rd_dly = $urandom_range(0, 4);
        wr_dly = $urandom_range(0, 4);
        src_q.delete();
        exp_q.delete();
        src_log.delete();
        for (int i = 0; i < int'(size); i++) begin
            if (mode) begin
                v = pattern + DW'(i);
            end else begin
                v = rnd_line();
                src_q.push_back(v);
                src_log.push_back(v);
            end
            exp_q.push_back(v);
        end
        ph = M_START;
`ifdef DMA_BURST_PERF_EN
        m_cyc = '0;
`endif
    endtask

    // DMA channel emulation, per-cycle compare and model advance
    always @(negedge clk) begin
        logic busy_e, done_e, rgo_e, wgo_e;
        logic push_e, rden_e, wren_e;
        int   occ;
        dif.dma_empty = (src_q.size() == 0) ||
                        ($urandom_range(99) < empty_pct);
        dif.dma_rd_data = (src_q.size() != 0) ? src_q[0] : rnd_line();
        dif.dma_full = force_full ||
                       ($urandom_range(99) < full_pct);
        dif.dma_rd_done = (post_rd == rd_dly);
        dif.dma_wr_done = (post_wr == wr_dly);
        #1;
        if (!rst) mreset();
        occ    = pushes - pops;
        busy_e = (ph == M_START || ph == M_XFER || ph == M_DRAIN);
        done_e = (ph == M_DONE);
        wgo_e  = (ph == M_START) && (m_size != 0);
        rgo_e  = wgo_e && !m_mode;
        push_e = (ph == M_XFER) && (occ < FD) &&
                 (pushes < int'(m_size)) &&
                 (m_mode || !dif.dma_empty);
        rden_e = push_e && !m_mode;
        wren_e = (ph == M_XFER) && (occ > 0) && !dif.dma_full;

        check("busy", busy, busy_e);
        check("done", done, done_e);
        check("rd_go", dif.dma_rd_go, rgo_e);
        check("wr_go", dif.dma_wr_go, wgo_e);
        check("rd_en", dif.dma_rd_en, rden_e);
        check("wr_en", dif.dma_wr_en, wren_e);
        check("rd_addr", dif.dma_rd_addr, m_rd);
        check("wr_addr", dif.dma_wr_addr, m_wr);
        check("rd_size", dif.dma_rd_size, m_size);
        check("wr_size", dif.dma_wr_size, m_size);
`ifdef DMA_BURST_PERF_EN
        check("cycle_count", cycle_count, m_cyc);
`endif
        if (!rst) check("reset_wr_data", dif.dma_wr_data, '0);
        if (wren_e && dif.dma_wr_en) begin
            wlog.push_back(dif.dma_wr_data);
            if (exp_q.size() == 0) begin
                checks++;
                errs++;
                $display("FAIL wr_extra: got %0h want none",
                         dif.dma_wr_data);
            end else begin
                check("wr_data", dif.dma_wr_data, exp_q[0]);
            end
        end

        n_rd_en += int'(dif.dma_rd_en);
        n_wr_en += int'(dif.dma_wr_en);
        n_rd_go += int'(dif.dma_rd_go);
        n_wr_go += int'(dif.dma_wr_go);
        if (done && !done_prev) n_done_rise++;
        done_prev = done;

        if (rst) begin
            if (busy_e) begin
                rd_seen |= dif.dma_rd_done;
                wr_seen |= dif.dma_wr_done;
            end
`ifdef DMA_BURST_PERF_EN
            if (busy_e && m_cyc != '1) m_cyc++;
`endif
            case (ph)
                M_IDLE, M_DONE: if (go && !go_prev) maccept();
                M_START: ph = (m_size == 0) ? M_DONE : M_XFER;
                M_XFER:  if (pops == int'(m_size)) ph = M_DRAIN;
                M_DRAIN: if (wr_seen && (m_mode || rd_seen)) ph = M_DONE;
                default: ph = M_IDLE;
            endcase
            if (push_e) begin
                pushes++;
                if (!m_mode && src_q.size() != 0) void'(src_q.pop_front());
            end
            if (wren_e) begin
                pops++;
                if (exp_q.size() != 0) void'(exp_q.pop_front());
            end
            if (post_rd >= 0) begin
                if (post_rd < 100) post_rd++;
            end else if (!m_mode && m_size != 0 &&
                         pushes == int'(m_size)) begin
                post_rd = 0;
            end
            if (post_wr >= 0) begin
                if (post_wr < 100) post_wr++;
            end else if (m_size != 0 && pops == int'(m_size)) begin
                post_wr = 0;
            end
            go_prev = go;
        end
    end

    task automatic kick(input bit md, input int sz,
                        input logic [DW-1:0] pat);
        @(negedge clk);
        b_rd = n_rd_en;
        b_wr = n_wr_en;
        b_rg = n_rd_go;
        b_wg = n_wr_go;
        b_dn = n_done_rise;
        b_wl = wlog.size();
        mode = md;
        size = SW'(sz);
        pattern = pat;
        rd_base = {$urandom, $urandom};
        wr_base = {$urandom, $urandom};
        go = 1'b1;
        @(negedge clk);
        go = 1'b0;
    endtask

    task automatic wait_done(input int lim);
        bit ok = 0;
        for (int i = 0; i < lim; i++) begin
            @(negedge clk);
            #2;
            if (done) begin
                ok = 1;
                break;
            end
        end
        checks++;
        if (!ok) begin
            errs++;
            $display("FAIL done_timeout: got done=0 want done=1");
        end
    endtask

    task automatic wait_wr(input int n, input int lim);
        bit ok = 0;
        for (int i = 0; i < lim; i++) begin
            @(negedge clk);
            #2;
            if (n_wr_en - b_wr >= n) begin
                ok = 1;
                break;
            end
        end
        checks++;
        if (!ok) begin
            errs++;
            $display("FAIL wr_timeout: got %0d want %0d",
                     n_wr_en - b_wr, n);
        end
    endtask

    initial begin
        int rd_rel;
        int wr_rel;
        int bad;
        repeat (3) @(negedge clk);
        #2;
        check("reset_busy", busy, 0);
        check("reset_done", done, 0);
        check("reset_wr_en", dif.dma_wr_en, 0);
        check("reset_rd_addr", dif.dma_rd_addr, 0);
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);

        // Copy, no stalls
        kick(0, 4, '0);
        wait_done(200);
        check("copy_rd_en_n", n_rd_en - b_rd, 4);
        check("copy_wr_en_n", n_wr_en - b_wr, 4);
        check("copy_done", done, 1);
        check("copy_busy", busy, 0);
        for (int i = 0; i < 4; i++) begin
            check("copy_order", wlog[b_wl + i], src_log[i]);
        end

        // Fill with a small seed
        kick(1, 3, 512'h10);
        wait_done(200);
        check("fill_w0", wlog[b_wl], 512'h10);
        check("fill_w1", wlog[b_wl + 1], 512'h11);
        check("fill_w2", wlog[b_wl + 2], 512'h12);
        check("fill_wr_n", n_wr_en - b_wr, 3);
        check("fill_rd_go", n_rd_go - b_rg, 0);
        check("fill_rd_en", n_rd_en - b_rd, 0);
        check("fill_done", done, 1);

        // Fill wraps modulo 2^DATA_WIDTH
        kick(1, 2, '1);
        wait_done(200);
        check("wrap_w0", wlog[b_wl], '1);
        check("wrap_w1", wlog[b_wl + 1], '0);

        // Zero-length transfer
        @(negedge clk);
        b_rd = n_rd_en;
        b_wr = n_wr_en;
        b_rg = n_rd_go;
        b_wg = n_wr_go;
        size = '0;
        mode = 1'b0;
        go = 1'b1;
        @(negedge clk);
        go = 1'b0;
        #2;
        check("zero_c1_done", done, 0);
        check("zero_c1_busy", busy, 1);
        @(negedge clk);
        #2;
        check("zero_c2_done", done, 1);
        check("zero_c2_busy", busy, 0);
        check("zero_gos", (n_rd_go - b_rg) + (n_wr_go - b_wg), 0);
        check("zero_ens", (n_rd_en - b_rd) + (n_wr_en - b_wr), 0);

        // Write backpressure for 20 cycles
        force_full = 1;
        rd_rel = -1;
        wr_rel = -1;
        fork
            begin
                repeat (20) @(negedge clk);
                rd_rel = n_rd_en - b_rd;
                wr_rel = n_wr_en - b_wr;
                force_full = 0;
            end
        join_none
        kick(0, 16, '0);
        wait_done(400);
        check("bp_rd_at_release", rd_rel, 8);
        check("bp_wr_at_release", wr_rel, 0);
        check("bp_wr_n", n_wr_en - b_wr, 16);
        bad = 0;
        for (int i = 0; i < 16; i++) begin
            if (wlog[b_wl + i] !== src_log[i]) bad++;
        end
        check("bp_order_bad", bad, 0);

        // Reset in the middle of a transfer
        kick(0, 10, '0);
        wait_wr(5, 200);
        @(negedge clk);
        rst = 1'b0;
        #2;
        check("mid_rst_busy", busy, 0);
        check("mid_rst_done", done, 0);
        check("mid_rst_rd_en", dif.dma_rd_en, 0);
        check("mid_rst_wr_en", dif.dma_wr_en, 0);
        check("mid_rst_wr_go", dif.dma_wr_go, 0);
        check("mid_rst_wr_size", dif.dma_wr_size, 0);
        check("mid_rst_wr_addr", dif.dma_wr_addr, 0);
        @(negedge clk);
        rst = 1'b1;
        kick(0, 2, '0);
        wait_done(200);
        check("post_rst_wr_n", n_wr_en - b_wr, 2);
        check("post_rst_done", done, 1);

        // A second go while transferring is ignored
        empty_pct = 30;
        full_pct = 30;
        kick(0, 12, '0);
        wait_wr(3, 300);
        @(negedge clk);
        size = SW'(5);
        go = 1'b1;
        @(negedge clk);
        go = 1'b0;
        wait_done(600);
        check("gob_wr_size", dif.dma_wr_size, 12);
        check("gob_rd_size", dif.dma_rd_size, 12);
        check("gob_done_once", n_done_rise - b_dn, 1);
        check("gob_wr_n", n_wr_en - b_wr, 12);

        // Random transfers
        for (int t = 0; t < 25; t++) begin
            int sz;
            bit md;
            sz = $urandom_range(0, 40);
            md = 1'($urandom_range(0, 1));
            empty_pct = $urandom_range(0, 50);
            full_pct = $urandom_range(0, 50);
            kick(md, sz, rnd_line());
            wait_done(20 * sz + 100);
            check("rand_wr_n", n_wr_en - b_wr, sz);
        end

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
